ltsm_ctrl: RTL and testbench



---
 rtl/ltsm_pkg.sv | 35 +++
 rtl/ltsm_timer.sv | 27 ++
 rtl/ltsm_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ltsm_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltsm_pkg.sv
// Shared types and constants for the link-training state machine.
// State codes follow the training order; pin-select codes match the pad mux encoding.
package ltsm_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_SBINIT     = 3'd1,
        ST_MBINIT     = 3'd2,
        ST_MBTRAIN    = 3'd3,
        ST_LINKINIT   = 3'd4,
        ST_ACTIVE     = 3'd5,
        ST_L1_L2      = 3'd6,
        ST_TRAINERROR = 3'd7
    } lt_state_e;

    typedef enum logic [1:0] {
        SB_Z    = 2'd0,
        SB_DIS  = 2'd1,
        SB_INIT = 2'd2,
        SB_COMS = 2'd3
    } sb_sel_e;

    typedef enum logic [1:0] {
        MB_Z    = 2'd0,
        MB_DIS  = 2'd1,
        MB_INIT = 2'd2,
        MB_COMS = 2'd3
    } mb_sel_e;

    localparam int PH_SBINIT   = 0;
    localparam int PH_MBINIT   = 1;
    localparam int PH_MBTRAIN  = 2;
    localparam int PH_LINKINIT = 3;

endpackage

// File: rtl/ltsm_timer.sv
// Up-counter with synchronous clear and a terminal-count flag; holds at the terminal value.
module ltsm_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != i_term)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/ltsm_ctrl.sv
// Link-training state machine: sequences SBINIT..LINKINIT, handles low power,
// timeouts, lane qualification and bounded retry with lockout.
module ltsm_ctrl
    import ltsm_pkg::*;
#(
    parameter int NUM_LANES         = 16,
    parameter int MIN_LANES         = 8,
    parameter int RESET_WAIT_CYCLES = 400000,
    parameter int TIMEOUT_CYCLES    = 800000,
    parameter int ERROR_HOLD_CYCLES = 1000,
    parameter int MAX_RETRIES       = 3
) (
    input  logic                             clk_100MHz,
    input  logic                             reset_n,
    input  logic                             enable_i,
    input  logic                             start_LT_i,
    output logic [3:0]                       phase_start_o,
    input  logic [3:0]                       phase_done_i,
    input  logic [3:0]                       phase_err_i,
    input  logic [NUM_LANES-1:0]             lane_good_i,
    output logic [NUM_LANES-1:0]             lane_mask_o,
    input  logic                             l1_req_i,
    input  logic                             l1_exit_i,
    output logic [2:0]                       state_o,
    output logic [1:0]                       SB_pin_sel_o,
    output logic [1:0]                       MB_pin_sel_o,
    output logic                             link_up_o,
    output logic                             train_error_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt_o
);

    localparam int DW = $clog2(RESET_WAIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(ERROR_HOLD_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CW = $clog2(NUM_LANES + 1);

    lt_state_e            r_state, w_next;
    sb_sel_e              w_sb_sel;
    mb_sel_e              w_mb_sel;
    logic                 w_state_chg, w_mask_load, w_lanes_ok;
    logic                 w_dwell_en, w_tout_en, w_hold_en;
    logic                 w_dwell_tc, w_tout_tc, w_hold_tc;
    logic [CW-1:0]        w_good_cnt;
    logic [RW-1:0]        r_retry, w_retry_inc;
    logic                 r_train_err;
    logic [3:0]           r_phase_start;
    logic [NUM_LANES-1:0] r_lane_mask;

    assign w_state_chg = (w_next != r_state);
    assign w_dwell_en  = (r_state == ST_RESET);
    assign w_tout_en   = (r_state == ST_SBINIT) || (r_state == ST_MBINIT) ||
                         (r_state == ST_MBTRAIN) || (r_state == ST_LINKINIT);
    assign w_hold_en   = (r_state == ST_TRAINERROR);
    assign w_retry_inc = (r_retry == RW'(MAX_RETRIES)) ? r_retry : r_retry + RW'(1);

    ltsm_timer #(.W(DW)) u_dwell (
        .i_clk(clk_100MHz), .i_rst_n(reset_n), .i_clr(w_state_chg), .i_en(w_dwell_en),
        .i_term(DW'(RESET_WAIT_CYCLES - 1)), .o_tc(w_dwell_tc)
    );

    ltsm_timer #(.W(TW)) u_timeout (
        .i_clk(clk_100MHz), .i_rst_n(reset_n), .i_clr(w_state_chg), .i_en(w_tout_en),
        .i_term(TW'(TIMEOUT_CYCLES - 1)), .o_tc(w_tout_tc)
    );

    ltsm_timer #(.W(HW)) u_hold (
        .i_clk(clk_100MHz), .i_rst_n(reset_n), .i_clr(w_state_chg), .i_en(w_hold_en),
        .i_term(HW'(ERROR_HOLD_CYCLES - 1)), .o_tc(w_hold_tc)
    );

    always_comb begin
        w_good_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_good_cnt = w_good_cnt + CW'(lane_good_i[i]);
        end
        w_lanes_ok = (w_good_cnt >= CW'(MIN_LANES));
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority within a training state: error pulse, then timeout, then done.
    always_comb begin
        w_next      = r_state;
        w_mask_load = 1'b0;
        if (!enable_i) begin
            w_next = ST_RESET;
        end else begin
            case (r_state)
                ST_RESET: if (w_dwell_tc && start_LT_i) w_next = ST_SBINIT;
                ST_SBINIT: begin
                    if (phase_err_i[PH_SBINIT] || w_tout_tc)  w_next = ST_TRAINERROR;
                    else if (phase_done_i[PH_SBINIT])         w_next = ST_MBINIT;
                end
                ST_MBINIT: begin
                    if (phase_err_i[PH_MBINIT] || w_tout_tc) begin
                        w_next = ST_TRAINERROR;
                    end else if (phase_done_i[PH_MBINIT]) begin
                        w_mask_load = 1'b1;
                        w_next      = w_lanes_ok ? ST_MBTRAIN : ST_TRAINERROR;
                    end
                end
                ST_MBTRAIN: begin
                    if (phase_err_i[PH_MBTRAIN] || w_tout_tc) w_next = ST_TRAINERROR;
                    else if (phase_done_i[PH_MBTRAIN])        w_next = ST_LINKINIT;
                end
                ST_LINKINIT: begin
                    if (phase_err_i[PH_LINKINIT] || w_tout_tc) w_next = ST_TRAINERROR;
                    else if (phase_done_i[PH_LINKINIT])        w_next = ST_ACTIVE;
                end
                ST_ACTIVE:     if (l1_req_i)  w_next = ST_L1_L2;
                ST_L1_L2:      if (l1_exit_i) w_next = ST_MBTRAIN;
                ST_TRAINERROR: if ((r_retry != RW'(MAX_RETRIES)) && w_hold_tc) w_next = ST_RESET;
                default:       w_next = ST_RESET;
            endcase
        end
    end

    always_comb begin
        w_sb_sel = SB_DIS;
        w_mb_sel = MB_Z;
        case (r_state)
            ST_SBINIT:                           w_sb_sel = SB_INIT;
            ST_MBINIT, ST_MBTRAIN, ST_LINKINIT: begin
                w_sb_sel = SB_COMS;
                w_mb_sel = MB_INIT;
            end
            ST_ACTIVE: begin
                w_sb_sel = SB_COMS;
                w_mb_sel = MB_COMS;
            end
            ST_L1_L2: begin
                w_sb_sel = SB_COMS;
                w_mb_sel = MB_DIS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_phase_start <= '0;
            r_lane_mask   <= '0;
            r_retry       <= '0;
            r_train_err   <= 1'b0;
        end else begin
            r_phase_start <= '0;
            if (w_state_chg) begin
                case (w_next)
                    ST_SBINIT:   r_phase_start[PH_SBINIT]   <= 1'b1;
                    ST_MBINIT:   r_phase_start[PH_MBINIT]   <= 1'b1;
                    ST_MBTRAIN:  r_phase_start[PH_MBTRAIN]  <= 1'b1;
                    ST_LINKINIT: r_phase_start[PH_LINKINIT] <= 1'b1;
                    default: ;
                endcase
            end
            if (w_mask_load) r_lane_mask <= lane_good_i;
            if (!enable_i) begin
                r_retry     <= '0;
                r_train_err <= 1'b0;
            end else if (w_state_chg && (w_next == ST_TRAINERROR)) begin
                r_retry <= w_retry_inc;
                if (w_retry_inc == RW'(MAX_RETRIES)) r_train_err <= 1'b1;
            end else if (w_state_chg && (w_next == ST_ACTIVE)) begin
                r_retry <= '0;
            end
        end
    end

    assign state_o       = r_state;
    assign phase_start_o = r_phase_start;
    assign lane_mask_o   = r_lane_mask;
    assign retry_cnt_o   = r_retry;
    assign train_error_o = r_train_err;
    assign link_up_o     = (r_state == ST_ACTIVE);
    assign SB_pin_sel_o  = w_sb_sel;
    assign MB_pin_sel_o  = w_mb_sel;

endmodule

// File: tb/tb_ltsm_ctrl.sv
// Bench for ltsm_ctrl: behavioural reference compared every cycle, plus
// directed scenarios with hand-computed timing and value expectations.
module tb_ltsm_ctrl;

    localparam int NL    = 16;
    localparam int MINL  = 8;
    localparam int RWAIT = 10;
    localparam int TOUT  = 50;
    localparam int HOLD  = 5;
    localparam int MAXR  = 2;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable_i   = 1'b0;
    logic        start_LT_i = 1'b0;
    logic [3:0]  phase_done_i = '0;
    logic [3:0]  phase_err_i  = '0;
    logic [NL-1:0] lane_good_i = '0;
    logic        l1_req_i  = 1'b0;
    logic        l1_exit_i = 1'b0;
    logic [3:0]  phase_start_o;
    logic [NL-1:0] lane_mask_o;
    logic [2:0]  state_o;
    logic [1:0]  SB_pin_sel_o, MB_pin_sel_o;
    logic        link_up_o, train_error_o;
    logic [1:0]  retry_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    ltsm_ctrl #(
        .NUM_LANES(NL), .MIN_LANES(MINL), .RESET_WAIT_CYCLES(RWAIT),
        .TIMEOUT_CYCLES(TOUT), .ERROR_HOLD_CYCLES(HOLD), .MAX_RETRIES(MAXR)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable_i(enable_i),
        .start_LT_i(start_LT_i), .phase_start_o(phase_start_o),
        .phase_done_i(phase_done_i), .phase_err_i(phase_err_i),
        .lane_good_i(lane_good_i), .lane_mask_o(lane_mask_o),
        .l1_req_i(l1_req_i), .l1_exit_i(l1_exit_i), .state_o(state_o),
        .SB_pin_sel_o(SB_pin_sel_o), .MB_pin_sel_o(MB_pin_sel_o),
        .link_up_o(link_up_o), .train_error_o(train_error_o),
        .retry_cnt_o(retry_cnt_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: state codes 0..7 in training order; age = cycles spent in current state.
    int         m_st = 0, m_age = 0, m_retry = 0;
    bit         m_err = 0;
    logic [NL-1:0] m_mask = '0;
    logic [3:0] m_ps = '0;
    int sb_tab[8] = '{1, 2, 3, 3, 3, 3, 3, 1};
    int mb_tab[8] = '{0, 0, 2, 2, 2, 3, 1, 0};

    always @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            m_st = 0; m_age = 0; m_retry = 0; m_err = 0; m_mask = '0; m_ps = '0;
        end else begin : upd
            int ns;
            int p;
            ns = m_st;
            if (!enable_i) begin
                ns = 0;
            end else if (m_st == 0) begin
                if (m_age >= RWAIT - 1 && start_LT_i) ns = 1;
            end else if (m_st >= 1 && m_st <= 4) begin
                p = m_st - 1;
                if (phase_err_i[p] || m_age >= TOUT - 1) begin
                    ns = 7;
                end else if (phase_done_i[p]) begin
                    if (p == 1) begin
                        m_mask = lane_good_i;
                        ns = ($countones(lane_good_i) >= MINL) ? 3 : 7;
                    end else begin
                        ns = m_st + 1;
                    end
                end
            end else if (m_st == 5) begin
                if (l1_req_i) ns = 6;
            end else if (m_st == 6) begin
                if (l1_exit_i) ns = 3;
            end else begin
                if (m_retry < MAXR && m_age >= HOLD - 1) ns = 0;
            end
            m_ps = (ns != m_st && ns >= 1 && ns <= 4) ? 4'(1 << (ns - 1)) : 4'b0;
            if (!enable_i) begin
                m_retry = 0;
                m_err = 0;
            end else if (ns != m_st && ns == 7) begin
                m_retry = (m_retry < MAXR) ? m_retry + 1 : MAXR;
                if (m_retry == MAXR) m_err = 1;
            end else if (ns != m_st && ns == 5) begin
                m_retry = 0;
            end
            m_age = (ns != m_st) ? 0 : m_age + 1;
            m_st = ns;
        end
    end

    always @(negedge clk_100MHz) begin
        check("state", 32'(state_o), 32'(m_st));
        check("phase_start", 32'(phase_start_o), 32'(m_ps));
        check("lane_mask", 32'(lane_mask_o), 32'(m_mask));
        check("retry_cnt", 32'(retry_cnt_o), 32'(m_retry));
        check("train_error", 32'(train_error_o), 32'(m_err));
        check("link_up", 32'(link_up_o), 32'(m_st == 5));
        check("sb_sel", 32'(SB_pin_sel_o), 32'(sb_tab[m_st]));
        check("mb_sel", 32'(MB_pin_sel_o), 32'(mb_tab[m_st]));
    end

    task automatic tick();
        @(posedge clk_100MHz);
        #2;
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int lim, output int n);
        n = 0;
        while (state_o !== st && n < lim) begin
            tick();
            n++;
        end
        check(name, 32'(state_o), 32'(st));
    endtask

    // Done arrives three cycles after the phase start is seen.
    task automatic do_phase(input int p);
        tick();
        tick();
        phase_done_i[p] = 1'b1;
        tick();
        phase_done_i = '0;
    endtask

    initial begin
        int n;
        enable_i = 1'b1;
        start_LT_i = 1'b1;
        lane_good_i = 16'hFFFF;
        repeat (3) tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_sb", 32'(SB_pin_sel_o), 32'd1);
        check("rst_mb", 32'(MB_pin_sel_o), 32'd0);
        check("rst_mask", 32'(lane_mask_o), 32'd0);
        reset_n = 1'b1;

        // happy path
        wait_state("reach_sbinit", 3'd1, 40, n);
        check("sbinit_delay", 32'(n), 32'd10);
        check("start_sbinit", 32'(phase_start_o), 32'h1);
        do_phase(0);
        check("to_mbinit", 32'(state_o), 32'd2);
        check("start_mbinit", 32'(phase_start_o), 32'h2);
        do_phase(1);
        check("to_mbtrain", 32'(state_o), 32'd3);
        do_phase(2);
        check("to_linkinit", 32'(state_o), 32'd4);
        do_phase(3);
        check("active", 32'(state_o), 32'd5);
        check("link_up", 32'(link_up_o), 32'd1);
        check("mask_ffff", 32'(lane_mask_o), 32'hFFFF);
        check("mb_active", 32'(MB_pin_sel_o), 32'd3);

        // low power entry and exit
        l1_req_i = 1'b1;
        tick();
        l1_req_i = 1'b0;
        check("l1_state", 32'(state_o), 32'd6);
        check("l1_mb", 32'(MB_pin_sel_o), 32'd1);
        tick();
        tick();
        l1_exit_i = 1'b1;
        tick();
        l1_exit_i = 1'b0;
        check("l1_exit", 32'(state_o), 32'd3);
        check("l1_exit_start", 32'(phase_start_o), 32'h4);
        tick();
        check("start_one_cycle", 32'(phase_start_o), 32'h0);
        check("mask_kept", 32'(lane_mask_o), 32'hFFFF);
        phase_done_i[2] = 1'b1;
        tick();
        phase_done_i = '0;
        do_phase(3);
        check("re_active", 32'(state_o), 32'd5);

        // err and done together in MBTRAIN
        l1_req_i = 1'b1;
        tick();
        l1_req_i = 1'b0;
        l1_exit_i = 1'b1;
        tick();
        l1_exit_i = 1'b0;
        tick();
        phase_err_i[2] = 1'b1;
        phase_done_i[2] = 1'b1;
        tick();
        phase_err_i = '0;
        phase_done_i = '0;
        check("collision", 32'(state_o), 32'd7);
        check("collision_retry", 32'(retry_cnt_o), 32'd1);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        check("en_low_reset", 32'(state_o), 32'd0);
        check("en_low_retry", 32'(retry_cnt_o), 32'd0);

        // timeout in SBINIT
        wait_state("reach_sbinit2", 3'd1, 40, n);
        check("redwell", 32'(n), 32'd10);
        wait_state("reach_timeout", 3'd7, 80, n);
        check("timeout_delay", 32'(n), 32'd50);
        check("timeout_retry", 32'(retry_cnt_o), 32'd1);
        wait_state("hold_reset", 3'd0, 20, n);
        check("hold_delay", 32'(n), 32'd5);
        check("no_lockout", 32'(train_error_o), 32'd0);

        // lane failure twice gives lockout
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        wait_state("reach_sbinit3", 3'd1, 40, n);
        do_phase(0);
        lane_good_i = 16'h007F;
        do_phase(1);
        check("lane_fail", 32'(state_o), 32'd7);
        check("lane_fail_mask", 32'(lane_mask_o), 32'h007F);
        check("lane_fail_retry", 32'(retry_cnt_o), 32'd1);
        wait_state("hold_reset2", 3'd0, 20, n);
        check("hold_delay2", 32'(n), 32'd5);
        wait_state("reach_sbinit4", 3'd1, 40, n);
        check("redwell2", 32'(n), 32'd10);
        do_phase(0);
        do_phase(1);
        check("lane_fail2", 32'(state_o), 32'd7);
        check("retry_two", 32'(retry_cnt_o), 32'd2);
        check("lockout_flag", 32'(train_error_o), 32'd1);
        repeat (20) tick();
        check("lockout_stays", 32'(state_o), 32'd7);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        lane_good_i = 16'hFFFF;
        check("unlock_state", 32'(state_o), 32'd0);
        check("unlock_retry", 32'(retry_cnt_o), 32'd0);
        check("unlock_flag", 32'(train_error_o), 32'd0);

        // reset in the middle of MBTRAIN
        wait_state("reach_sbinit5", 3'd1, 40, n);
        do_phase(0);
        do_phase(1);
        check("pre_rst_mbtrain", 32'(state_o), 32'd3);
        tick();
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_start", 32'(phase_start_o), 32'd0);
        check("arst_mask", 32'(lane_mask_o), 32'd0);
        check("arst_retry", 32'(retry_cnt_o), 32'd0);
        check("arst_flag", 32'(train_error_o), 32'd0);
        check("arst_link", 32'(link_up_o), 32'd0);
        check("arst_sb", 32'(SB_pin_sel_o), 32'd1);
        check("arst_mb", 32'(MB_pin_sel_o), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_state("reach_sbinit6", 3'd1, 40, n);
        check("post_rst_dwell", 32'(n), 32'd10);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
